// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   MEM stage of the five-stage MIPS pipeline. Uses the ALU result as a byte
//   address, drives a single-port data memory through a req/ack handshake,
//   steers byte/half/word lanes and sign- or zero-extends loads. mem_stall
//   freezes the pipeline while an access is outstanding.
//
//   FSM: IDLE -> BUSY -> DONE -> IDLE. DONE is a one-cycle "release" state in
//   which the pipeline advances. Because DONE always returns to IDLE, the
//   instruction that just finished is never issued a second time.
//
// Optional feature (macro MEM_ALIGN_CHECK_EN):
//   defined   - misaligned half/word accesses raise mem_misalign for one cycle
//               and issue no memory request.
//   undefined - mem_misalign is absent; irrelevant low address bits are dropped.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   EXE_MEM_Result      byte address from the ALU
//   EXE_MEM_StoreData   store data (rt)
//   MemReadIn/WriteIn   load/store in MEM (both high = store)
//   MemSize             00 byte, 01 half, 1x word
//   MemSignExt          1 = sign-extend byte/half loads
//   dmem_*              data-memory handshake; all request fields registered
//   MEM_Result          registered, extended load data
//   mem_misalign        misaligned-access flag (MEM_ALIGN_CHECK_EN only)
//   mem_stall           1 = hold PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] EXE_MEM_Result,
  input  logic [31:0]       EXE_MEM_StoreData,
  input  logic              MemReadIn,
  input  logic              MemWriteIn,
  input  logic [1:0]        MemSize,
  input  logic              MemSignExt,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [31:0]       MEM_Result,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              mem_misalign,
`endif
  output logic              mem_stall
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [31:0]       r_result;
  // Load shape is kept for the ack cycle, when EX/MEM may no longer be valid.
  logic              r_is_load;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [1:0]        r_lane;

  logic              w_access;
  logic              w_is_load;
  logic [1:0]        w_a;
  logic [31:0]       w_wdata;
  logic [3:0]        w_be;

  assign w_access  = MemReadIn | MemWriteIn;
  // Read and write both high is treated as a store.
  assign w_is_load = MemReadIn & ~MemWriteIn;
  assign w_a       = EXE_MEM_Result[1:0];

  // Store lane steering: replicate the datum across the word and let the byte
  // enables pick the lanes.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_wdata = EXE_MEM_StoreData;
    w_be    = 4'b1111;
    case (MemSize)
      2'b00: begin
        w_wdata = {4{EXE_MEM_StoreData[7:0]}};
        w_be    = 4'b0001 << w_a;
      end
      2'b01: begin
        w_wdata = {2{EXE_MEM_StoreData[15:0]}};
        w_be    = w_a[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misalign;
  logic r_misalign;

  always_comb begin
    w_misalign = 1'b0;
    case (MemSize)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = w_a[0];
      default: w_misalign = (w_a != 2'b00);
    endcase
  end

  assign mem_misalign = r_misalign;
`endif

  // Load lane selection and extension from the registered access shape.
  function automatic logic [31:0] f_load_extend(
    input logic [31:0] rdata,
    input logic [1:0]  size,
    input logic        sext,
    input logic [1:0]  lane
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   f_load_extend = {{24{sext & b[7]}}, b};
      2'b01:   f_load_extend = {{16{sext & h[15]}}, h};
      default: f_load_extend = rdata;
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_result  <= '0;
      r_is_load <= 1'b0;
      r_size    <= '0;
      r_sext    <= 1'b0;
      r_lane    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (w_misalign) begin
              // Skip the memory entirely; a faulting load returns zero.
              r_misalign <= 1'b1;
              if (w_is_load) r_result <= '0;
              r_state <= ST_DONE;
            end else
`endif
            begin
              r_req     <= 1'b1;
              r_we      <= MemWriteIn;
              r_addr    <= {EXE_MEM_Result[ADDR_W-1:2], 2'b00};
              r_wdata   <= w_wdata;
              r_be      <= w_be;
              r_is_load <= w_is_load;
              r_size    <= MemSize;
              r_sext    <= MemSignExt;
              r_lane    <= w_a;
              r_state   <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            r_req <= 1'b0;
            if (r_is_load) r_result <= f_load_extend(dmem_rdata, r_size, r_sext, r_lane);
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
`ifdef MEM_ALIGN_CHECK_EN
          r_misalign <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall is combinational in IDLE so the access is held from its first cycle.
  assign mem_stall  = ((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY);
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign MEM_Result = r_result;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed test of mem_access_stage: reset values, asynchronous reset during
//   BUSY, store/load lane steering and extension, handshake latency and stall
//   pattern, spurious ack, and misaligned word access (behaviour depends on
//   MEM_ALIGN_CHECK_EN).
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic [31:0] EXE_MEM_Result;
  logic [31:0] EXE_MEM_StoreData;
  logic        MemReadIn;
  logic        MemWriteIn;
  logic [1:0]  MemSize;
  logic        MemSignExt;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] MEM_Result;
  logic        mem_stall;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_misalign;
`endif

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .EXE_MEM_Result    (EXE_MEM_Result),
    .EXE_MEM_StoreData (EXE_MEM_StoreData),
    .MemReadIn         (MemReadIn),
    .MemWriteIn        (MemWriteIn),
    .MemSize           (MemSize),
    .MemSignExt        (MemSignExt),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_rdata        (dmem_rdata),
    .dmem_ack          (dmem_ack),
    .MEM_Result        (MEM_Result),
`ifdef MEM_ALIGN_CHECK_EN
    .mem_misalign      (mem_misalign),
`endif
    .mem_stall         (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Count rising edges of dmem_req (sampled on the falling clock edge).
  int   req_rises = 0;
  logic prev_req  = 1'b0;
  always @(negedge clk) begin
    if (dmem_req && !prev_req) req_rises <= req_rises + 1;
    prev_req <= dmem_req;
  end

  // Values captured from the first request cycle of the last access.
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  logic        stable_ok;
  int          stall_cnt;

  // Present one memory instruction in IDLE, answer with ack after wait_n
  // BUSY cycles, and return in the DONE cycle (stall already checked as 0).
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sx, input logic [31:0] addr,
                            input logic [31:0] data, input int wait_n,
                            input logic [31:0] rdata);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    MemReadIn = rd; MemWriteIn = wr; MemSize = sz; MemSignExt = sx;
    EXE_MEM_Result = addr; EXE_MEM_StoreData = data;
    #1;
    stall_cnt = mem_stall ? 1 : 0;
    seen = 1'b0; stable_ok = 1'b1;
    cap_addr = '1; cap_wdata = '1; cap_be = '1; cap_we = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
    while (mem_stall && cyc < 50) begin
      stall_cnt++;
      if (dmem_req) begin
        if (!seen) begin
          cap_addr = dmem_addr; cap_wdata = dmem_wdata; cap_be = dmem_be; cap_we = dmem_we;
          seen = 1'b1;
        end else if (dmem_addr !== cap_addr || dmem_wdata !== cap_wdata ||
                     dmem_be !== cap_be || dmem_we !== cap_we) begin
          stable_ok = 1'b0;
        end
      end
      if (cyc == wait_n) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      cyc++;
    end
    check("done_stall", {31'b0, mem_stall}, 32'd0);
    check("done_req",   {31'b0, dmem_req},  32'd0);
    MemReadIn = 1'b0; MemWriteIn = 1'b0;
  endtask

  int r0;

  initial begin
    rst = 1'b1;
    EXE_MEM_Result = '0; EXE_MEM_StoreData = '0;
    MemReadIn = 1'b0; MemWriteIn = 1'b0; MemSize = 2'b10; MemSignExt = 1'b0;
    dmem_rdata = '0; dmem_ack = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req",    {31'b0, dmem_req},   32'd0);
    check("rst_we",     {31'b0, dmem_we},    32'd0);
    check("rst_addr",   dmem_addr,           32'd0);
    check("rst_wdata",  dmem_wdata,          32'd0);
    check("rst_be",     {28'b0, dmem_be},    32'd0);
    check("rst_result", MEM_Result,          32'd0);
    check("rst_stall",  {31'b0, mem_stall},  32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check("rst_misalign", {31'b0, mem_misalign}, 32'd0);
`endif
    rst = 1'b0;

    // Asynchronous reset in the middle of BUSY
    @(posedge clk); #1;
    MemWriteIn = 1'b1; MemSize = 2'b10; EXE_MEM_Result = 32'h30; EXE_MEM_StoreData = 32'h5555AAAA;
    @(posedge clk); #1;
    check("busy_req", {31'b0, dmem_req}, 32'd1);
    rst = 1'b1; MemWriteIn = 1'b0;
    #1;
    check("arst_req",   {31'b0, dmem_req},  32'd0);
    check("arst_be",    {28'b0, dmem_be},   32'd0);
    check("arst_stall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    r0 = req_rises;
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h01020304, 0, 32'h0);
    check("post_rst_stall", stall_cnt, 32'd2);
    check("post_rst_addr",  cap_addr, 32'h10);
    check("post_rst_reqs",  req_rises - r0, 32'd1);

    // sw 0xDEADBEEF to 0x20, two wait cycles
    r0 = req_rises;
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 2, 32'h0);
    check("sw_stall_cycles", stall_cnt, 32'd4);
    check("sw_addr",   cap_addr, 32'h20);
    check("sw_be",     {28'b0, cap_be}, 32'hF);
    check("sw_wdata",  cap_wdata, 32'hDEADBEEF);
    check("sw_we",     {31'b0, cap_we}, 32'd1);
    check("sw_stable", {31'b0, stable_ok}, 32'd1);
    @(posedge clk); #1;
    check("sw_reqs",       req_rises - r0, 32'd1);
    check("sw_idle_stall", {31'b0, mem_stall}, 32'd0);

    // lb / lbu from 0x23
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1, 32'h80FF0000);
    check("lb_result",  MEM_Result, 32'hFFFFFF80);
    check("lb_we",      {31'b0, cap_we}, 32'd0);
    check("lb_addr",    cap_addr, 32'h20);
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 0, 32'h80FF0000);
    check("lbu_result", MEM_Result, 32'h00000080);

    // sh to 0x42, then lh (zero-extend) from 0x42
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h42, 32'h1234ABCD, 0, 32'h0);
    check("sh_be",     {28'b0, cap_be}, 32'hC);
    check("sh_wdata",  cap_wdata, 32'hABCDABCD);
    check("sh_addr",   cap_addr, 32'h40);
    check("sh_hold",   MEM_Result, 32'h00000080);
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 0, 32'h80010000);
    check("lhu_result", MEM_Result, 32'h00008001);

    // Read+write both high behaves as a store
    run_access(1'b1, 1'b1, 2'b00, 1'b0, 32'h51, 32'h000000A5, 0, 32'h11111111);
    check("rw_we",    {31'b0, cap_we}, 32'd1);
    check("rw_be",    {28'b0, cap_be}, 32'h2);
    check("rw_wdata", cap_wdata, 32'hA5A5A5A5);
    check("rw_hold",  MEM_Result, 32'h00008001);

    // Back-to-back lw with immediate ack: stall 1,1,0,1,1,0
    r0 = req_rises;
    run_access(1'b1, 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, 0, 32'h11223344);
    check("lw1_stall",  stall_cnt, 32'd2);
    check("lw1_result", MEM_Result, 32'h11223344);
    run_access(1'b1, 1'b0, 2'b10, 1'b1, 32'h104, 32'h0, 0, 32'h85667788);
    check("lw2_stall",  stall_cnt, 32'd2);
    check("lw2_result", MEM_Result, 32'h85667788);
    @(posedge clk); #1;
    check("lw_reqs", req_rises - r0, 32'd2);

    // Spurious ack in IDLE is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("spur_req",    {31'b0, dmem_req},  32'd0);
    check("spur_stall",  {31'b0, mem_stall}, 32'd0);
    check("spur_result", MEM_Result, 32'h85667788);
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 0, 32'h000000C3);
    check("spur_next_stall",  stall_cnt, 32'd2);
    check("spur_next_result", MEM_Result, 32'h000000C3);

    // lw from 0x06
    r0 = req_rises;
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 0, 32'hCAFEF00D);
`ifdef MEM_ALIGN_CHECK_EN
    check("mis_stall",    stall_cnt, 32'd1);
    check("mis_flag",     {31'b0, mem_misalign}, 32'd1);
    check("mis_result",   MEM_Result, 32'd0);
    @(posedge clk); #1;
    check("mis_flag_clr", {31'b0, mem_misalign}, 32'd0);
    check("mis_reqs",     req_rises - r0, 32'd0);
`else
    check("lw6_addr",   cap_addr, 32'h04);
    check("lw6_be",     {28'b0, cap_be}, 32'hF);
    check("lw6_result", MEM_Result, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("lw6_reqs",   req_rises - r0, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
